// File: rtl/md_issue_ctrl.sv
// Decode-stage controller: RV32I/M decode plus a sequencer that issues M ops to an iterative mul/div unit.
// Optional MD_DIV0_BYPASS_EN: divide/remainder by zero is answered locally without starting the unit.
module md_issue_ctrl #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     inst_d,
  input  logic            valid_d,
  input  logic            flush,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            reg_wr,
  output logic            sel_a,
  output logic            sel_b,
  output logic [1:0]      wb_sel,
  output logic [2:0]      imm_src,
  output logic [4:0]      alu_op,
  output logic            illegal,
  output logic            is_md,
  output logic            stall_d,
  output logic            md_start,
  output logic [2:0]      md_op,
  output logic [XLEN-1:0] md_a,
  output logic [XLEN-1:0] md_b,
  input  logic            md_done,
  input  logic [XLEN-1:0] md_result,
  output logic            md_abort,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_err
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                         ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_LUI = 5'd10, ALU_MUL = 5'd11;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       shift_bad;
  logic       unused_fields;

  assign opcode = inst_d[6:0];
  assign funct3 = inst_d[14:12];
  assign funct7 = inst_d[31:25];
  assign unused_fields = ^inst_d[24:15];

  function automatic logic [4:0] base_alu(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_alu = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  // Immediate shifts reuse funct7 as the upper immediate bits, so only the legal encodings pass.
  assign shift_bad = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                     ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));

  always_comb begin
    reg_wr  = 1'b0;
    sel_a   = 1'b0;
    sel_b   = 1'b0;
    wb_sel  = 2'b00;
    imm_src = 3'b000;
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    is_md   = 1'b0;
    case (opcode)
      7'b0110011: begin
        if (funct7 == 7'b0000001) begin
          is_md  = 1'b1;
          sel_a  = 1'b1;
          wb_sel = 2'b01;
          alu_op = ALU_MUL + {2'b00, funct3};
        end else if ((funct7 == 7'b0000000) || (funct7 == 7'b0100000)) begin
          reg_wr = 1'b1;
          sel_a  = 1'b1;
          wb_sel = 2'b01;
          alu_op = base_alu(funct3, funct7[5]);
        end else begin
          illegal = 1'b1;
        end
      end
      7'b0010011: begin
        if (shift_bad) begin
          illegal = 1'b1;
        end else begin
          reg_wr = 1'b1;
          sel_a  = 1'b1;
          sel_b  = 1'b1;
          wb_sel = 2'b01;
          alu_op = base_alu(funct3, (funct3 == 3'b101) && funct7[5]);
        end
      end
      7'b0000011: begin reg_wr = 1'b1; sel_a = 1'b1; sel_b = 1'b1; wb_sel = 2'b10; end
      7'b0100011: begin sel_a = 1'b1; sel_b = 1'b1; imm_src = 3'b001; end
      7'b0110111: begin reg_wr = 1'b1; sel_b = 1'b1; wb_sel = 2'b01; imm_src = 3'b100; alu_op = ALU_LUI; end
      7'b0010111: begin reg_wr = 1'b1; sel_b = 1'b1; wb_sel = 2'b01; imm_src = 3'b100; end
      7'b1100011: begin sel_b = 1'b1; imm_src = 3'b010; end
      7'b1101111: begin reg_wr = 1'b1; sel_b = 1'b1; imm_src = 3'b011; end
      7'b1100111: begin reg_wr = 1'b1; sel_a = 1'b1; sel_b = 1'b1; end
      default:    illegal = 1'b1;
    endcase
  end

  state_t          state_reg, state_next;
  logic [TW-1:0]   timer_reg;
  logic [4:0]      rd_reg;
  logic [2:0]      op_reg;
  logic [XLEN-1:0] a_reg, b_reg, wb_data_reg;
  logic            wb_err_reg;
  logic            accept, timeout_hit, div0_byp;

  assign accept      = (state_reg == S_IDLE) && valid_d && is_md && !flush;
  assign timeout_hit = (timer_reg == TW'(TIMEOUT - 1));
`ifdef MD_DIV0_BYPASS_EN
  assign div0_byp = funct3[2] && (rs2_val == '0);
`else
  assign div0_byp = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    stall_d    = 1'b0;
    md_start   = 1'b0;
    md_abort   = 1'b0;
    wb_valid   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        stall_d = accept;
        if (accept) state_next = div0_byp ? S_WB : S_ISSUE;
      end
      S_ISSUE: begin
        stall_d    = 1'b1;
        md_start   = 1'b1;
        md_abort   = flush;
        state_next = flush ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        stall_d = 1'b1;
        if (flush) begin
          md_abort   = 1'b1;
          state_next = S_IDLE;
        end else if (md_done) begin
          state_next = S_WB;
        end else if (timeout_hit) begin
          md_abort   = 1'b1;
          state_next = S_WB;
        end
      end
      default: begin
        wb_valid   = !flush && (rd_reg != 5'd0);
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      timer_reg   <= '0;
      rd_reg      <= '0;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      wb_data_reg <= '0;
      wb_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_IDLE: if (accept) begin
          rd_reg      <= inst_d[11:7];
          op_reg      <= funct3;
          a_reg       <= rs1_val;
          b_reg       <= rs2_val;
          wb_err_reg  <= 1'b0;
          // Divide by zero yields all-ones; remainder by zero yields the dividend.
          wb_data_reg <= div0_byp ? (funct3[1] ? rs1_val : '1) : '0;
        end
        S_ISSUE: timer_reg <= '0;
        S_WAIT: if (!flush) begin
          if (md_done) begin
            wb_data_reg <= md_result;
            wb_err_reg  <= 1'b0;
          end else if (timeout_hit) begin
            wb_data_reg <= '0;
            wb_err_reg  <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign md_op   = op_reg;
  assign md_a    = a_reg;
  assign md_b    = b_reg;
  assign wb_rd   = rd_reg;
  assign wb_data = wb_data_reg;
  assign wb_err  = wb_err_reg;
endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed decode vectors plus M-op sequences checked by an event scoreboard.
module tb_md_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst_d = 32'h0;
  logic        valid_d = 1'b0, flush = 1'b0, md_done = 1'b0;
  logic [31:0] rs1_val = 32'h0, rs2_val = 32'h0, md_result = 32'h0;
  logic        reg_wr, sel_a, sel_b, illegal, is_md, stall_d, md_start, md_abort, wb_valid, wb_err;
  logic [1:0]  wb_sel;
  logic [2:0]  imm_src, md_op;
  logic [4:0]  alu_op, wb_rd;
  logic [31:0] md_a, md_b, wb_data;

  md_issue_ctrl #(.XLEN(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .inst_d(inst_d), .valid_d(valid_d), .flush(flush),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .reg_wr(reg_wr), .sel_a(sel_a), .sel_b(sel_b),
    .wb_sel(wb_sel), .imm_src(imm_src), .alu_op(alu_op), .illegal(illegal), .is_md(is_md),
    .stall_d(stall_d), .md_start(md_start), .md_op(md_op), .md_a(md_a), .md_b(md_b),
    .md_done(md_done), .md_result(md_result), .md_abort(md_abort), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // Expected DUT events: kind 0 = md_start, 1 = md_abort, 2 = wb_valid.
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  rd;
    logic        err;
    logic [2:0]  op;
  } ev_t;
  ev_t sb[$];

  function automatic void push_ev(int kind, int c, logic [31:0] d0, logic [31:0] d1,
                                  logic [4:0] rd, logic err, logic [2:0] op);
    ev_t e;
    e.kind = kind; e.cyc = c; e.d0 = d0; e.d1 = d1; e.rd = rd; e.err = err; e.op = op;
    sb.push_back(e);
  endfunction

  task automatic take(input int kind, input string name, output ev_t e, output logic ok);
    ok = 1'b0;
    e = '{default: 0};
    if (sb.size() == 0) begin
      chk({name, "_unexpected"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_kind"}, kind, e.kind);
      chk({name, "_cycle"}, cyc, e.cyc);
      ok = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    ev_t  e;
    logic ok;
    if (!rst) begin
      if (md_start) begin
        $display("txn cyc=%0d md_start op=%0d a=%h b=%h", cyc, md_op, md_a, md_b);
        take(0, "md_start", e, ok);
        if (ok) begin
          chk("md_a", md_a, e.d0);
          chk("md_b", md_b, e.d1);
          chk("md_op", {29'b0, md_op}, {29'b0, e.op});
        end
      end
      if (md_abort) begin
        $display("txn cyc=%0d md_abort", cyc);
        take(1, "md_abort", e, ok);
      end
      if (wb_valid) begin
        $display("txn cyc=%0d wb rd=%0d data=%h err=%0b", cyc, wb_rd, wb_data, wb_err);
        take(2, "wb", e, ok);
        if (ok) begin
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          chk("wb_data", wb_data, e.d0);
          chk("wb_err", {31'b0, wb_err}, {31'b0, e.err});
        end
      end
    end
  end

  task automatic dec(input logic [31:0] inst, input logic [4:0] alu, input logic rw, input logic ill,
                     input logic md, input logic hs, input logic sa, input logic sb_i,
                     input logic [1:0] wbs, input logic [2:0] imm);
    inst_d = inst;
    @(negedge clk);
    $display("txn decode inst=%h alu_op=%0d reg_wr=%0b illegal=%0b is_md=%0b", inst, alu_op, reg_wr, illegal, is_md);
    chk("alu_op", {27'b0, alu_op}, {27'b0, alu});
    chk("reg_wr", {31'b0, reg_wr}, {31'b0, rw});
    chk("illegal", {31'b0, illegal}, {31'b0, ill});
    chk("is_md", {31'b0, is_md}, {31'b0, md});
    chk("dec_stall_d", {31'b0, stall_d}, 32'd0);
    if (hs) chk("selects", {23'b0, sel_a, sel_b, wb_sel, imm_src}, {23'b0, sa, sb_i, wbs, imm});
    @(posedge clk); #1;
  endtask

  // Runs one M-op from cycle T = cyc at entry; k is the cycle offset from T.
  task automatic run_md(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int done_at, input int flush_at,
                        input int stall_last, input int last);
    inst_d = inst; rs1_val = a; rs2_val = b; md_result = res;
    for (int k = 0; k <= last; k++) begin
      valid_d = (k == 0);
      md_done = (k == done_at);
      flush   = (k == flush_at);
      @(negedge clk);
      chk("stall_d", {31'b0, stall_d}, (k <= stall_last) ? 32'd1 : 32'd0);
      @(posedge clk); #1;
    end
    valid_d = 1'b0; md_done = 1'b0; flush = 1'b0;
  endtask

  task automatic run_div0(input logic [31:0] inst, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    int t;
    t = cyc;
`ifdef MD_DIV0_BYPASS_EN
    push_ev(2, t + 1, exp, 0, 5'd5, 1'b0, 3'd0);
    run_md(inst, a, 32'h0, 32'h0, -1, -1, 0, 3);
`else
    push_ev(0, t + 1, a, 32'h0, 5'd0, 1'b0, f3);
    push_ev(2, t + 3, exp, 0, 5'd5, 1'b0, 3'd0);
    run_md(inst, a, 32'h0, exp, 2, -1, 2, 4);
`endif
  endtask

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_stall_d", {31'b0, stall_d}, 32'd0);
    chk("rst_md_start", {31'b0, md_start}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_md_abort", {31'b0, md_abort}, 32'd0);
    chk("rst_wb_regs", {wb_err, wb_rd, wb_data[25:0]}, 32'd0);
    @(posedge clk); #1;

    dec(32'h002081B3, 5'd0,  1, 0, 0, 0, 0, 0, 2'b00, 3'b000);
    dec(32'h402081B3, 5'd1,  1, 0, 0, 0, 0, 0, 2'b00, 3'b000);
    dec(32'h4020D1B3, 5'd7,  1, 0, 0, 0, 0, 0, 2'b00, 3'b000);
    dec(32'h042081B3, 5'd0,  0, 1, 0, 1, 0, 0, 2'b00, 3'b000);
    dec(32'h022081B3, 5'd11, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000);
    dec(32'h0220C2B3, 5'd15, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000);
    dec(32'h0220F2B3, 5'd18, 0, 0, 1, 0, 0, 0, 2'b00, 3'b000);
    dec(32'h40209193, 5'd0,  0, 1, 0, 1, 0, 0, 2'b00, 3'b000);
    dec(32'h4020D193, 5'd7,  1, 0, 0, 1, 1, 1, 2'b01, 3'b000);
    dec(32'h0000007F, 5'd0,  0, 1, 0, 1, 0, 0, 2'b00, 3'b000);
    dec(32'h000011B7, 5'd10, 1, 0, 0, 1, 0, 1, 2'b01, 3'b100);

    // MUL x3 = 7*6, unit answers five cycles after md_start.
    t = cyc;
    push_ev(0, t + 1, 32'd7, 32'd6, 5'd0, 1'b0, 3'd0);
    push_ev(2, t + 7, 32'd42, 0, 5'd3, 1'b0, 3'd0);
    run_md(32'h022081B3, 32'd7, 32'd6, 32'd42, 6, -1, 6, 8);

    // Unit never answers: 16 WAIT cycles, abort, then error writeback.
    t = cyc;
    push_ev(0, t + 1, 32'd3, 32'd5, 5'd0, 1'b0, 3'd0);
    push_ev(1, t + 17, 0, 0, 5'd0, 1'b0, 3'd0);
    push_ev(2, t + 18, 32'd0, 0, 5'd3, 1'b1, 3'd0);
    run_md(32'h022081B3, 32'd3, 32'd5, 32'd99, -1, -1, 17, 20);

    // Flush coinciding with md_done in WAIT: abort, no writeback.
    t = cyc;
    push_ev(0, t + 1, 32'd9, 32'd2, 5'd0, 1'b0, 3'd0);
    push_ev(1, t + 3, 0, 0, 5'd0, 1'b0, 3'd0);
    run_md(32'h02208233, 32'd9, 32'd2, 32'd18, 3, 3, 3, 5);

    // Flush in IDLE blocks acceptance.
    run_md(32'h02208233, 32'd1, 32'd1, 32'd1, -1, 0, -1, 2);

    // Destination x0: the unit runs but no writeback is presented.
    t = cyc;
    push_ev(0, t + 1, 32'd4, 32'd4, 5'd0, 1'b0, 3'd0);
    run_md(32'h02208033, 32'd4, 32'd4, 32'd16, 2, -1, 2, 4);

    run_div0(32'h0220C2B3, 3'd4, 32'd100, 32'hFFFFFFFF);
    run_div0(32'h0220E2B3, 3'd6, 32'd100, 32'd100);

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
